scs8hd_dlxtn_wrctl: RTL

//  Write controller directly upstream of a WIDTH-bit bank of negative-transparent
//  D-latches (dlxtn-style bank: D in, GATEN active-low gate, Q out).

---
 rtl/scs8hd_dlxtn_wrctl.sv | 113 +++++++++++
 1 files changed

// File: rtl/scs8hd_dlxtn_wrctl.sv
// rtl/scs8hd_dlxtn_wrctl.sv - latch-safe write sequencer for a dlxtn-style latch bank
module scs8hd_dlxtn_wrctl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             REQ,
    input  logic [WIDTH-1:0] WDATA,
    output logic             BUSY,
    output logic             ACK,
    output logic             MISMATCH,
    output logic [WIDTH-1:0] D,
    output logic             GATEN,
    input  logic [WIDTH-1:0] Q_FB
);

    // Longest phase sets the counter width; the counter only counts down
    // to zero and is reloaded on every state change, so it never wraps.
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_OPEN  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    // A zero-length phase would break the latch timing guarantees outright.
    generate
        if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
            $error("scs8hd_dlxtn_wrctl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
        end
    endgenerate

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    // Sequencer: every output is a register, updated alongside the state.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            D        <= '0;
            GATEN    <= 1'b1;
            BUSY     <= 1'b0;
            ACK      <= 1'b0;
            MISMATCH <= 1'b0;
        end else begin
            ACK <= 1'b0;
            case (state)
                ST_IDLE: begin
                    GATEN <= 1'b1;
                    if (REQ) begin
                        D        <= WDATA;
                        MISMATCH <= 1'b0;
                        cnt      <= SETUP_LD;
                        BUSY     <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        GATEN <= 1'b0;
                        cnt   <= PULSE_LD;
                        state <= ST_OPEN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_OPEN: begin
                    if (cnt == '0) begin
                        GATEN <= 1'b1;
                        cnt   <= HOLD_LD;
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        ACK   <= 1'b1;
                        cnt   <= '0;
                        state <= ST_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_CHECK: begin
                    // Unknown bits on the readback are treated as a failed write.
                    MISMATCH <= (Q_FB !== D);
                    BUSY     <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    GATEN <= 1'b1;
                    BUSY  <= 1'b0;
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
